cdc_hs_rx: RTL and testbench
============================

// Module: cdc_hs_rx
// PURPOSE
// - Destination-domain receiver of a 4-phase req/ack CDC handshake. Sits directly
//   downstream of the cdc_sync synchroniser that carries the source req.
// - Captures the source-held data bus when the synchronised req rises and presents it
//   as a valid/ready stream. Drives ack back to the source, which re-synchronises it.
// - Implements the full 4-phase sequence, including protection against spurious
//   capture after reset.
// PARAMETERS
// - DATA_WIDTH      32    width of dat_i / dat_o
// - TIMEOUT_CYCLES  1024  watchdog limit, in clk_i cycles (used only with CDC_HS_RX_TIMEOUT_EN)
// PORTS
// - clk_i      in   1           destination clock; single clock domain
// - rst_i      in   1           reset, synchronous, active-high
// - req_i      in   1           source req, already synchronised to clk_i (cdc_sync output)
// - dat_i      in   DATA_WIDTH  source data; stable from source req rise until ack_o is seen
// - ack_o      out  1           ack to source domain; registered, glitch-free
// - valid_o    out  1           dat_o holds a captured word
// - ready_i    in   1           downstream accepts the word
// - dat_o      out  DATA_WIDTH  captured data, registered
// - busy_o     out  1           state != IDLE
// - err_o      out  1           sticky watchdog flag (only with CDC_HS_RX_TIMEOUT_EN)
// - err_clr_i  in   1           clears err_o (only with CDC_HS_RX_TIMEOUT_EN)
// BEHAVIOUR
// - Reset values (rst_i high at an edge): state=RESYNC, ack_o=0, valid_o=0, dat_o=0,
//   busy_o=1, err_o=0, watchdog counter=0.
// - FSM states:
//   - RESYNC: wait for req_i==0, then go to IDLE. This prevents re-capturing a stale
//     request that was in flight when reset hit.
//   - IDLE: if req_i==1 at edge N, set dat_o<=dat_i and valid_o<=1, go to VALID.
//     valid_o is therefore high in the cycle after edge N (1-cycle latency).
//   - VALID: hold valid_o=1 and dat_o stable until valid_o&&ready_i at edge M.
//     At M: valid_o<=0, ack_o<=1, go to ACK. ack_o is never raised before the transfer.
//   - ACK: hold ack_o=1 until req_i==0 at edge K. At K: ack_o<=0, go to IDLE.
// - ready_i is ignored when valid_o==0. valid_o never drops without the transfer.
// - dat_o keeps its last value after a transfer; it changes only on capture in IDLE.
// - A req_i that falls while the FSM is in VALID is a protocol violation. The FSM still
//   completes the transfer, then ACK sees req_i==0 and returns to IDLE one cycle later.
// - Minimum spacing: a new capture needs req_i low for at least one edge (edge K), so the
//   earliest next capture is edge K+1. Sustained throughput is bounded by the
//   synchroniser round trip, not by this block.
// - busy_o is combinational from the state register: 1 in RESYNC, VALID and ACK.
// CONFIGURATION
// - Macro `CDC_HS_RX_TIMEOUT_EN`:
//   - Defined: adds err_o, err_clr_i and a $clog2(TIMEOUT_CYCLES+1)-bit counter.
//   - The counter clears on every state change, increments each cycle in VALID or ACK,
//     and saturates at TIMEOUT_CYCLES.
//   - When the counter equals TIMEOUT_CYCLES-1 at an edge, err_o<=1 (sticky).
//   - The FSM is not aborted and data is not dropped.
//   - err_clr_i==1 at an edge clears err_o, unless the set condition also holds at that
//     edge; set wins.
//   - Not defined: no err_o/err_clr_i ports and no counter logic; all other behaviour
//     is identical.
// TESTING
// - Basic transfer: after reset, req_i=0 for 2 cycles, then req_i=1 with dat_i=32'hA5A5_0001,
//   ready_i=1.
//   -> valid_o=1 and dat_o=32'hA5A5_0001 one cycle later; ack_o=1 the next cycle.
//   -> After req_i=0, ack_o=0 and busy_o=0 one cycle later.
// - Backpressure: ready_i=0 for 10 cycles after capture of 32'h0000_BEEF.
//   -> valid_o stays 1, dat_o stays 32'h0000_BEEF, ack_o stays 0.
//   -> ready_i=1 for one cycle gives ack_o=1 the next cycle.
// - Reset mid-ACK: rst_i pulsed with req_i still 1.
//   -> valid_o=0, ack_o=0, no new capture while req_i stays 1 for 5 cycles.
//   -> After req_i low then high with dat_i=32'h1234, exactly one capture of 32'h1234.
// - Back-to-back: 8 transfers with dat_i=0..7, source returning req after the ack edge,
//   random ready_i.
//   -> Sink sees 0..7 in order, no duplicates or losses.
//   -> ack_o rises exactly 8 times.
// - Timeout (macro on, TIMEOUT_CYCLES=16): ready_i=0 for 20 cycles.
//   -> err_o=1 after 16 cycles in VALID, and stays 1 after the transfer completes.
//   -> err_clr_i pulse gives err_o=0.
// - Macro off: same stimulus as Timeout.
//   -> Builds without err ports; transfer completes normally.

Source files
------------

// File: rtl/cdc_hs_rx.sv
// cdc_hs_rx: destination side of a 4-phase req/ack handshake, presented as a valid/ready stream.
// Capture-to-valid is 1 cycle; ack is raised only after the downstream accepts. `CDC_HS_RX_TIMEOUT_EN adds a watchdog.
module cdc_hs_rx #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  ack_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  busy_o
`ifdef CDC_HS_RX_TIMEOUT_EN
  ,
  output logic                  err_o,
  input  logic                  err_clr_i
`endif
);

  if (DATA_WIDTH < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("cdc_hs_rx: DATA_WIDTH must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {
    ST_RESYNC,
    ST_IDLE,
    ST_VALID,
    ST_ACK
  } state_t;

  state_t state;

  // RESYNC swallows a request that was still high when reset hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_RESYNC;
      ack_o   <= 1'b0;
      valid_o <= 1'b0;
      dat_o   <= '0;
    end else begin
      case (state)
        ST_RESYNC: begin
          if (!req_i) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (req_i) begin
            dat_o   <= dat_i;
            valid_o <= 1'b1;
            state   <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ack_o   <= 1'b1;
            state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!req_i) begin
            ack_o <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_RESYNC;
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE);

`ifdef CDC_HS_RX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SET = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wdog_cnt;
  logic             state_chg;

  always_comb begin
    state_chg = 1'b0;
    case (state)
      ST_RESYNC: state_chg = !req_i;
      ST_IDLE:   state_chg = req_i;
      ST_VALID:  state_chg = ready_i;
      ST_ACK:    state_chg = !req_i;
      default:   state_chg = 1'b1;
    endcase
  end

  // Watchdog only flags a stalled handshake; it never aborts the FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      if (state_chg) begin
        wdog_cnt <= '0;
      end else if ((state == ST_VALID || state == ST_ACK) && wdog_cnt != CNT_MAX) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
      if (wdog_cnt == CNT_SET) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Bench for cdc_hs_rx: protocol-level model with per-cycle compare, sink scoreboard and directed literal checks.
// Works with and without `CDC_HS_RX_TIMEOUT_EN.
module tb_cdc_hs_rx;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          ready = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] dat = '0;
  logic          ack, valid, busy, err;
  logic [DW-1:0] dat_out;

  always #5 clk = ~clk;

  cdc_hs_rx #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .dat_i(dat),
    .ack_o(ack), .valid_o(valid), .ready_i(ready), .dat_o(dat_out), .busy_o(busy)
`ifdef CDC_HS_RX_TIMEOUT_EN
    , .err_o(err), .err_clr_i(err_clr)
`endif
  );
`ifndef CDC_HS_RX_TIMEOUT_EN
  assign err = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int n_xfer = 0;
  int n_ackrise = 0;
  bit cmp_en = 0;
  bit ack_prev = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Protocol model: armed = req seen low since reset; holding = word offered; acking = waiting for req low.
  bit            m_armed, m_hold, m_acking, m_err;
  logic [DW-1:0] m_dat;
  int            m_age;
  logic [2:0]    m_phase_old;

  always @(posedge clk) begin
    if (rst) begin
      m_armed = 0; m_hold = 0; m_acking = 0; m_err = 0; m_dat = '0; m_age = 0;
    end else begin
      m_phase_old = {m_armed, m_hold, m_acking};
      if (m_age == TO - 1) m_err = 1;
      else if (err_clr) m_err = 0;
      if (!m_armed) begin
        if (!req) m_armed = 1;
      end else if (m_hold) begin
        if (ready) begin m_hold = 0; m_acking = 1; end
      end else if (m_acking) begin
        if (!req) m_acking = 0;
      end else if (req) begin
        m_hold = 1; m_dat = dat;
      end
      if ({m_armed, m_hold, m_acking} != m_phase_old) m_age = 0;
      else if ((m_hold || m_acking) && m_age < TO) m_age++;
    end
  end

  // Sink scoreboard: every accepted word must be the oldest word the source offered.
  always @(posedge clk) begin
    if (!rst && valid === 1'b1 && ready === 1'b1) begin
      n_xfer++;
      if (exp_q.size() == 0) chk("sink_unexpected_word", dat_out, 'x);
      else chk("sink_order", dat_out, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_valid", {31'b0, valid}, {31'b0, m_hold});
      chk("cyc_ack", {31'b0, ack}, {31'b0, m_acking});
      chk("cyc_dat", dat_out, m_dat);
      chk("cyc_busy", {31'b0, busy}, {31'b0, !(m_armed && !m_hold && !m_acking)});
`ifdef CDC_HS_RX_TIMEOUT_EN
      chk("cyc_err", {31'b0, err}, {31'b0, m_err});
`endif
      if (ack === 1'b1 && !ack_prev) n_ackrise++;
      ack_prev = (ack === 1'b1);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (2) cyc();
    cmp_en = 1;
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_ack", {31'b0, ack}, 0);
    chk("rst_dat", dat_out, 0);
    chk("rst_busy", {31'b0, busy}, 1);
    chk("rst_err", {31'b0, err}, 0);
    rst = 0;

    // Basic transfer
    repeat (2) cyc();
    chk("basic_idle_busy", {31'b0, busy}, 0);
    req = 1; dat = 32'hA5A5_0001; ready = 1; exp_q.push_back(dat);
    cyc();
    chk("basic_valid", {31'b0, valid}, 1);
    chk("basic_dat", dat_out, 32'hA5A5_0001);
    chk("basic_ack_not_early", {31'b0, ack}, 0);
    cyc();
    chk("basic_ack", {31'b0, ack}, 1);
    req = 0;
    cyc();
    chk("basic_ack_low", {31'b0, ack}, 0);
    chk("basic_busy_low", {31'b0, busy}, 0);

    // Backpressure
    req = 1; dat = 32'h0000_BEEF; ready = 0; exp_q.push_back(dat);
    cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_valid", {31'b0, valid}, 1);
      chk("bp_dat", dat_out, 32'h0000_BEEF);
      chk("bp_ack", {31'b0, ack}, 0);
    end
    ready = 1;
    cyc();
    chk("bp_ack_after_ready", {31'b0, ack}, 1);
    ready = 0; req = 0;
    cyc();
    chk("bp_ack_low", {31'b0, ack}, 0);

    // Reset mid-ACK with req still high
    req = 1; dat = 32'h0000_0055; ready = 1; exp_q.push_back(dat);
    repeat (2) cyc();
    chk("rma_in_ack", {31'b0, ack}, 1);
    ready = 0; rst = 1;
    cyc();
    rst = 0;
    chk("rma_valid", {31'b0, valid}, 0);
    chk("rma_ack", {31'b0, ack}, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rma_no_capture", {31'b0, valid}, 0);
      chk("rma_busy", {31'b0, busy}, 1);
    end
    req = 0;
    cyc();
    chk("rma_idle", {31'b0, busy}, 0);
    req = 1; dat = 32'h0000_1234; exp_q.push_back(dat);
    cyc();
    chk("rma_capture", dat_out, 32'h0000_1234);
    ready = 1;
    cyc();
    chk("rma_ack2", {31'b0, ack}, 1);
    ready = 0; req = 0;
    cyc();

    // Req drops while the word is still held
    req = 1; dat = 32'h0000_C0DE; exp_q.push_back(dat);
    cyc();
    req = 0;
    repeat (2) cyc();
    chk("viol_valid_held", {31'b0, valid}, 1);
    ready = 1;
    cyc();
    chk("viol_ack", {31'b0, ack}, 1);
    ready = 0;
    cyc();
    chk("viol_ack_low", {31'b0, ack}, 0);
    chk("viol_idle", {31'b0, busy}, 0);

    // Back-to-back with random ready
    for (int w = 0; w < 8; w++) begin
      req = 1; dat = w; exp_q.push_back(dat);
      for (int c = 0; c < 100 && ack !== 1'b1; c++) begin
        ready = 1'($urandom_range(0, 1));
        cyc();
      end
      chk("b2b_ack_seen", {31'b0, ack}, 1);
      req = 0;
      cyc();
      chk("b2b_ack_low", {31'b0, ack}, 0);
    end
    ready = 0;

    // Watchdog stimulus (plain transfer when the watchdog is absent)
    req = 1; dat = 32'h0000_7777; exp_q.push_back(dat);
    cyc();
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("to_valid", {31'b0, valid}, 1);
`ifdef CDC_HS_RX_TIMEOUT_EN
      chk("to_err", {31'b0, err}, (k >= 16) ? 1 : 0);
`endif
    end
    ready = 1;
    cyc();
    chk("to_ack", {31'b0, ack}, 1);
    ready = 0; req = 0;
    cyc();
    chk("to_done", {31'b0, busy}, 0);
`ifdef CDC_HS_RX_TIMEOUT_EN
    chk("to_err_sticky", {31'b0, err}, 1);
    err_clr = 1;
    cyc();
    err_clr = 0;
    chk("to_err_clr", {31'b0, err}, 0);
`endif

    repeat (2) cyc();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_xfers", n_xfer, 14);
    chk("final_ack_rises", n_ackrise, 14);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
